// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite transfer codes and copy-master state encoding
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_A, WR_D, FIN} copy_state_t;
endpackage

// File: rtl/ahb_copy_master.sv
// ahb_copy_master: AHB-Lite master copying len words from src_addr to dst_addr
module ahb_copy_master
  import ahb_pkg::*;
#(
  parameter int LENW = 16
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            start,
  input  logic [31:0]     src_addr,
  input  logic [31:0]     dst_addr,
  input  logic [LENW-1:0] len,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [31:0]     HADDR,
  output logic [1:0]      HTRANS,
  output logic            HWRITE,
  output logic [2:0]      HSIZE,
  output logic [31:0]     HWDATA,
  input  logic [31:0]     HRDATA,
  input  logic            HREADY,
  input  logic            HRESP
);
  copy_state_t state, state_nx;
  logic [31:0] src, dst, data;
  logic [LENW-1:0] cnt;
  logic accept, rd_ok, wr_ok, err_set;
  always_comb begin
    accept  = state == IDLE && start;
    rd_ok   = state == RD_D && HREADY && !HRESP;
    wr_ok   = state == WR_D && HREADY && !HRESP;
    err_set = (state == RD_D || state == WR_D) && HREADY && HRESP;
    state_nx = state;
    case (state)
      IDLE:    state_nx = !start ? IDLE : (len != '0 ? RD_A : FIN);
      RD_A:    state_nx = HREADY ? RD_D : RD_A;
      RD_D:    state_nx = !HREADY ? RD_D : (HRESP ? FIN : WR_A);
      WR_A:    state_nx = HREADY ? WR_D : WR_A;
      WR_D:    state_nx = !HREADY ? WR_D : ((HRESP || cnt == LENW'(1)) ? FIN : RD_A);
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
      src   <= '0;
      dst   <= '0;
      cnt   <= '0;
      data  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept && len != '0) begin
        src <= {src_addr[31:2], 2'b00};
        dst <= {dst_addr[31:2], 2'b00};
        cnt <= len;
      end
      if (accept) err <= 1'b0;
      else if (err_set) err <= 1'b1;
      if (rd_ok) data <= HRDATA;
      if (wr_ok) begin
        src <= src + 32'd4;
        dst <= dst + 32'd4;
        cnt <= cnt - LENW'(1);
      end
    end
  end
  // Bus outputs decode registered state only, so they are glitch-free and idle under reset
  always_comb begin
    busy   = state != IDLE && state != FIN;
    done   = state == FIN;
    HTRANS = (state == RD_A || state == WR_A) ? HTRANS_NONSEQ : HTRANS_IDLE;
    HWRITE = state == WR_A;
    HADDR  = state == WR_A ? dst : src;
    HSIZE  = HSIZE_WORD;
    HWDATA = data;
  end
endmodule

// File: tb/tb_ahb_copy_master.sv
// tb_ahb_copy_master: directed copies against a transaction-queue model and a wait/error slave
module tb_ahb_copy_master;
  logic HCLK = 1'b0, HRESETn = 1'b0, start = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0;
  logic [15:0] len = '0;
  logic busy, done, err, HWRITE, HREADY, HRESP;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0] HTRANS;
  logic [2:0] HSIZE;
  ahb_copy_master #(.LENW(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .busy(busy), .done(done), .err(err), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );
  always #5 HCLK = ~HCLK;
  int checks = 0, failures = 0;
  int cycle_ctr = 0;
  always @(posedge HCLK) cycle_ctr <= cycle_ctr + 1;
  typedef struct {bit w; logic [31:0] a; logic [31:0] d;} xfer_t;
  xfer_t exq[$];
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  int W = 0;
  logic [31:0] err_addr = '0;
  bit err_en = 1'b0, active = 1'b0;
  int acc = 0, D = 0;
  logic [31:0] wd = '0;
  logic pend, pw, es, is_err;
  logic [31:0] pa;
  int wc;
  function automatic logic [31:0] init_word(input int i);
    return i < 4 ? 32'h11111111 * 32'(i + 1) : (32'hA0000000 | 32'(i));
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  // Slave: data phase lasts W+1 cycles; a read of err_addr gets the two-cycle ERROR response
  assign is_err = pend && !pw && err_en && pa == err_addr;
  assign HREADY = !pend || (is_err ? es : wc == 0);
  assign HRESP  = is_err;
  assign HRDATA = (pend && !pw) ? mem[pa[11:2]] : 32'h0;
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend <= 1'b0; pw <= 1'b0; pa <= '0; wc <= 0; es <= 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
    end else if (pend && !HREADY) begin
      if (is_err) es <= 1'b1;
      else wc <= wc - 1;
    end else begin
      if (pend && pw) mem[pa[11:2]] <= HWDATA;
      pend <= HTRANS == 2'b10; pa <= HADDR; pw <= HWRITE; wc <= W; es <= 1'b0;
    end
  end
  always @(negedge HCLK) begin
    int c;
    if (HRESETn) begin
      chk("hsize", 32'(HSIZE), 32'h2);
      if (HTRANS == 2'b10) begin
        if (exq.size() == 0) chk("spurious_nonseq", HADDR, 32'hFFFF_FFFF);
        else begin
          chk("haddr", HADDR, exq[0].a);
          chk("hwrite", 32'(HWRITE), 32'(exq[0].w));
          if (HREADY) begin
            if (exq[0].w) wd = exq[0].d;
            void'(exq.pop_front());
          end
        end
      end else chk("htrans_idle", 32'(HTRANS), 32'h0);
      if (pend && pw && HREADY) chk("hwdata", HWDATA, wd);
      c = cycle_ctr - acc;
      chk("done", 32'(done), 32'(active && c == D));
      chk("busy", 32'(busy), 32'(active && c < D));
    end
  end
  task automatic ref_init();
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
  endtask
  task automatic plan(input logic [31:0] s0, d0, input int n, w, input bit ee, input int lit, output bit e);
    logic [31:0] s, t, x;
    int dd;
    s = s0 & ~32'h3; t = d0 & ~32'h3; dd = 0; e = 1'b0;
    for (int i = 0; i < n; i++) begin
      exq.push_back('{1'b0, s, 32'h0});
      if (ee && s == err_addr) begin
        dd += 3; e = 1'b1;
        break;
      end
      dd += 2 + w;
      x = ref_mem[s[11:2]];
      exq.push_back('{1'b1, t, x});
      ref_mem[t[11:2]] = x;
      dd += 2 + w;
      s += 4; t += 4;
    end
    D = dd;
    if (lit >= 0) chk("model_latency", 32'(dd), 32'(lit));
  endtask
  task automatic launch(input logic [31:0] s0, d0, input int n);
    @(negedge HCLK);
    start = 1'b1; src_addr = s0; dst_addr = d0; len = 16'(n);
    @(posedge HCLK); #1;
    acc = cycle_ctr; active = 1'b1; start = 1'b0;
  endtask
  task automatic copy(input logic [31:0] s0, d0, input int n, w, input logic [31:0] ea,
                      input bit ee, spam, input int lit);
    bit e;
    int c, mism;
    W = w; err_addr = ea; err_en = ee;
    plan(s0, d0, n, w, ee, lit, e);
    launch(s0, d0, n);
    c = 0;
    while (c <= D + 2) begin
      if (spam) begin
        start = c >= 5 && c <= D;
        src_addr = $urandom; dst_addr = $urandom; len = 16'($urandom);
      end
      @(posedge HCLK); #1;
      c = cycle_ctr - acc;
    end
    start = 1'b0; active = 1'b0;
    chk("xfers_left", 32'(exq.size()), 32'h0);
    chk("err", 32'(err), 32'(e));
    mism = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("mem_match", 32'(mism), 32'h0);
  endtask
  initial begin
    bit e;
    int k;
    ref_init();
    #1;
    chk("rst_htrans", 32'(HTRANS), 32'h0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwrite", 32'(HWRITE), 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_hsize", 32'(HSIZE), 32'h2);
    chk("rst_busy_done_err", {29'h0, busy, done, err}, 32'h0);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    copy(32'h000, 32'h100, 4, 0, 32'h0, 1'b0, 1'b0, 16);
    chk("basic_w0", mem[32'h40], 32'h11111111);
    chk("basic_w3", mem[32'h43], 32'h44444444);
    copy(32'h040, 32'h140, 0, 0, 32'h0, 1'b0, 1'b0, 0);
    copy(32'h003, 32'h182, 2, 2, 32'h0, 1'b0, 1'b0, 16);
    chk("wait_w1", mem[32'h61], 32'h22222222);
    copy(32'h000, 32'h300, 3, 0, 32'h4, 1'b1, 1'b0, 7);
    chk("err_w0", mem[32'hC0], 32'h11111111);
    chk("err_w1_untouched", mem[32'hC1], 32'hA00000C1);
    copy(32'hFFFF_FFF8, 32'hFFFF_FFFC, 3, 0, 32'h0, 1'b0, 1'b1, 12);
    chk("wrap_w2", mem[1], 32'hA00003FE);
    W = 0; err_en = 1'b0;
    plan(32'h000, 32'h100, 4, 0, 1'b0, -1, e);
    launch(32'h000, 32'h100, 4);
    k = 0;
    while (!(HTRANS == 2'b10 && HWRITE) && k < 20) begin
      @(posedge HCLK); #1;
      k++;
    end
    chk("reach_wr_a", 32'(k < 20), 32'h1);
    HRESETn = 1'b0;
    #1;
    active = 1'b0;
    exq.delete();
    ref_init();
    chk("midrst_htrans", 32'(HTRANS), 32'h0);
    chk("midrst_busy_done", {30'h0, busy, done}, 32'h0);
    repeat (2) @(posedge HCLK);
    #1;
    chk("midrst_hold", {27'h0, HTRANS, busy, done, err}, 32'h0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    copy(32'h000, 32'h100, 4, 1, 32'h0, 1'b0, 1'b0, 24);
    chk("post_rst_w2", mem[32'h42], 32'h33333333);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
